// File: rtl/dmem_ctrl_if.sv
// Load/store bus between the datapath and dmem_ctrl.
// The datapath drives the request side; the memory returns read data and ready.
interface dmem_ctrl_if #(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 16,
  parameter int LANE_WIDTH = 8
);
  logic                             en;
  logic                             we;
  logic [DATA_WIDTH/LANE_WIDTH-1:0] be;
  logic [ADDR_WIDTH-1:0]            addr;
  logic [DATA_WIDTH-1:0]            di;
  logic                             clr;
  logic [DATA_WIDTH-1:0]            dout;
  logic                             rvalid;
  logic                             ready;

  modport master (
    output en, we, be, addr, di, clr,
    input  dout, rvalid, ready
  );

  modport slave (
    input  en, we, be, addr, di, clr,
    output dout, rvalid, ready
  );
endinterface

// File: rtl/dmem_ctrl.sv
// Data memory with byte-lane strobes, selectable read timing and a clear sequencer.
//
// state   | meaning
// S_IDLE  | accesses accepted, ready=1
// S_CLEAR | writing zero to word[r_ptr], one word per cycle, ready=0
module dmem_ctrl #(
  parameter int ADDR_WIDTH     = 6,
  parameter int DATA_WIDTH     = 16,
  parameter int LANE_WIDTH     = 8,
  parameter int READ_MODE      = 0,
  parameter int CLEAR_ON_RESET = 1
) (
  input logic        clk,
  input logic        rst,
  dmem_ctrl_if.slave bus
);
  localparam int DEPTH  = 1 << ADDR_WIDTH;
  localparam int NLANES = DATA_WIDTH / LANE_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST_PTR = ADDR_WIDTH'(DEPTH - 1);

  if ((DATA_WIDTH % LANE_WIDTH) != 0) begin : g_bad_lane
    $error("dmem_ctrl: DATA_WIDTH must be a multiple of LANE_WIDTH");
  end
  if ((READ_MODE < 0) || (READ_MODE > 2)) begin : g_bad_mode
    $error("dmem_ctrl: READ_MODE must be 0, 1 or 2");
  end

  typedef enum logic {S_IDLE, S_CLEAR} state_t;
  localparam state_t RST_STATE = (CLEAR_ON_RESET != 0) ? S_CLEAR : S_IDLE;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_ptr;
  logic [ADDR_WIDTH-1:0] w_ptr_nxt;
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  logic                  w_ready;
  logic                  w_acc;
  logic                  w_mem_we;
  logic [ADDR_WIDTH-1:0] w_waddr;
  logic [DATA_WIDTH-1:0] w_wdata;
  logic [DATA_WIDTH-1:0] w_rd_word;
  logic [DATA_WIDTH-1:0] w_merged;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= RST_STATE;
      r_ptr   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    case (r_state)
      S_IDLE: begin
        if (bus.clr) begin
          w_state_nxt = S_CLEAR;
          w_ptr_nxt   = '0;
        end
      end
      S_CLEAR: begin
        w_ptr_nxt = r_ptr + 1'b1;
        if (r_ptr == LAST_PTR) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_ptr_nxt   = '0;
      end
    endcase
  end

  assign w_ready   = (r_state == S_IDLE);
  // A clear request wins over any access presented on the same edge.
  assign w_acc     = w_ready & bus.en & ~bus.clr;
  assign w_rd_word = r_mem[bus.addr];

  always_comb begin
    w_merged = w_rd_word;
    for (int i = 0; i < NLANES; i++) begin
      if (bus.be[i]) begin
        w_merged[i*LANE_WIDTH +: LANE_WIDTH] = bus.di[i*LANE_WIDTH +: LANE_WIDTH];
      end
    end
  end

  always_comb begin
    w_mem_we = 1'b0;
    w_waddr  = bus.addr;
    w_wdata  = w_merged;
    if (r_state == S_CLEAR) begin
      w_mem_we = 1'b1;
      w_waddr  = r_ptr;
      w_wdata  = '0;
    end else if (w_acc && bus.we) begin
      w_mem_we = 1'b1;
    end
  end

  // Array has no reset; only the clear sequencer zeroes it.
  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      r_mem[w_waddr] <= w_wdata;
    end
  end

  assign bus.ready = w_ready;

  if (READ_MODE == 0) begin : g_async_rd
    assign bus.dout   = w_ready ? w_rd_word : '0;
    assign bus.rvalid = bus.en & w_ready;
  end else begin : g_sync_rd
    logic [DATA_WIDTH-1:0] r_dout;
    logic                  r_rvalid;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_dout   <= '0;
        r_rvalid <= 1'b0;
      end else begin
        r_rvalid <= w_acc;
        if (w_acc) begin
          r_dout <= (READ_MODE == 1) ? w_rd_word : w_merged;
        end
      end
    end

    assign bus.dout   = r_dout;
    assign bus.rvalid = r_rvalid;
  end
endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed bench: four dmem_ctrl instances (async/read-first/write-first/no-reset-clear)
// share one stimulus stream so every read mode sees identical memory contents.
module tb_dmem_ctrl;
  logic        clk;
  logic        rst;
  logic        en, we, clr;
  logic [1:0]  be;
  logic [5:0]  addr;
  logic [15:0] di;
  int          total;
  int          bad;
  int          low;

  dmem_ctrl_if #(.ADDR_WIDTH(6), .DATA_WIDTH(16), .LANE_WIDTH(8)) b0 ();
  dmem_ctrl_if #(.ADDR_WIDTH(6), .DATA_WIDTH(16), .LANE_WIDTH(8)) b1 ();
  dmem_ctrl_if #(.ADDR_WIDTH(6), .DATA_WIDTH(16), .LANE_WIDTH(8)) b2 ();
  dmem_ctrl_if #(.ADDR_WIDTH(6), .DATA_WIDTH(16), .LANE_WIDTH(8)) b3 ();

  assign b0.en = en; assign b0.we = we; assign b0.be = be; assign b0.addr = addr; assign b0.di = di; assign b0.clr = clr;
  assign b1.en = en; assign b1.we = we; assign b1.be = be; assign b1.addr = addr; assign b1.di = di; assign b1.clr = clr;
  assign b2.en = en; assign b2.we = we; assign b2.be = be; assign b2.addr = addr; assign b2.di = di; assign b2.clr = clr;
  assign b3.en = en; assign b3.we = we; assign b3.be = be; assign b3.addr = addr; assign b3.di = di; assign b3.clr = clr;

  dmem_ctrl #(.READ_MODE(0), .CLEAR_ON_RESET(1)) dut0 (.clk(clk), .rst(rst), .bus(b0));
  dmem_ctrl #(.READ_MODE(1), .CLEAR_ON_RESET(1)) dut1 (.clk(clk), .rst(rst), .bus(b1));
  dmem_ctrl #(.READ_MODE(2), .CLEAR_ON_RESET(1)) dut2 (.clk(clk), .rst(rst), .bus(b2));
  dmem_ctrl #(.READ_MODE(0), .CLEAR_ON_RESET(0)) dut3 (.clk(clk), .rst(rst), .bus(b3));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    total = 0; bad = 0;
    rst = 1'b1; en = 1'b0; we = 1'b0; clr = 1'b0; be = 2'b00; addr = '0; di = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready_m1", 16'(b1.ready), 16'h0);
    chk("rst_dout_m0", b0.dout, 16'h0000);
    chk("rst_dout_m1", b1.dout, 16'h0000);
    chk("rst_rvalid_m2", 16'(b2.rvalid), 16'h0);
    chk("rst_ready_noclr", 16'(b3.ready), 16'h1);

    rst = 1'b0;
    #1;
    low = 0;
    while (b1.ready !== 1'b1 && low < 200) begin
      low++;
      tick();
    end
    chk("reset_clear_len", 16'(low), 16'd64);
    chk("ready_m0_after_clr", 16'(b0.ready), 16'h1);
    chk("ready_m2_after_clr", 16'(b2.ready), 16'h1);

    en = 1'b1;
    for (int a = 0; a < 64; a++) begin
      addr = 6'(a);
      #1;
      chk($sformatf("post_reset_rd_%0d", a), b0.dout, 16'h0000);
    end

    // same-edge write/read ordering
    we = 1'b1; addr = 6'd5; di = 16'hABCD; be = 2'b11;
    tick();
    chk("m1_pre_write", b1.dout, 16'h0000);
    chk("m1_rvalid", 16'(b1.rvalid), 16'h1);
    chk("m2_post_write", b2.dout, 16'hABCD);
    chk("m0_after_write", b0.dout, 16'hABCD);
    di = 16'h1234;
    tick();
    chk("m1_old_abcd", b1.dout, 16'hABCD);
    chk("m2_new_1234", b2.dout, 16'h1234);
    chk("m0_new_1234", b0.dout, 16'h1234);
    we = 1'b0;
    tick();
    chk("m1_read_1234", b1.dout, 16'h1234);

    we = 1'b1; di = 16'hABCD; be = 2'b11;
    tick();
    di = 16'h1234; be = 2'b01;
    tick();
    chk("m2_lane0_merge", b2.dout, 16'hAB34);
    chk("m1_lane0_old", b1.dout, 16'hABCD);
    be = 2'b00; di = 16'h5555;
    tick();
    chk("m2_be0_nop", b2.dout, 16'hAB34);
    chk("m1_be0_read", b1.dout, 16'hAB34);
    chk("m0_be0_word", b0.dout, 16'hAB34);
    en = 1'b0; we = 1'b0;
    tick();
    chk("m1_idle_rvalid", 16'(b1.rvalid), 16'h0);
    chk("m1_idle_hold", b1.dout, 16'hAB34);
    chk("m0_idle_rvalid", 16'(b0.rvalid), 16'h0);

    // async read visibility
    en = 1'b1; we = 1'b1; addr = 6'd9; di = 16'h00FF; be = 2'b11;
    #1;
    chk("m0_before_edge", b0.dout, 16'h0000);
    tick();
    we = 1'b0;
    #1;
    chk("m0_addr9", b0.dout, 16'h00FF);
    chk("m0_rvalid_en", 16'(b0.rvalid), 16'h1);
    en = 1'b0;
    #1;
    chk("m0_rvalid_off", 16'(b0.rvalid), 16'h0);

    en = 1'b1; we = 1'b1; be = 2'b11; di = 16'hFFFF;
    for (int a = 0; a < 64; a++) begin
      addr = 6'(a);
      tick();
    end
    we = 1'b0; addr = 6'd63;
    tick();
    chk("fill_m1_63", b1.dout, 16'hFFFF);
    addr = 6'd0;
    #1;
    chk("fill_m0_0", b0.dout, 16'hFFFF);

    en = 1'b0; clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("clr_ready_low", 16'(b1.ready), 16'h0);
    chk("clr_m0_dout0", b0.dout, 16'h0000);
    chk("clr_m1_hold", b1.dout, 16'hFFFF);
    en = 1'b1; we = 1'b1; addr = 6'd7; di = 16'h1234; be = 2'b11;
    low = 0;
    while (b1.ready !== 1'b1 && low < 200) begin
      if (low == 10) chk("clr_m1_rvalid", 16'(b1.rvalid), 16'h0);
      low++;
      tick();
    end
    en = 1'b0; we = 1'b0;
    chk("clr_len", 16'(low), 16'd64);
    en = 1'b1;
    for (int a = 0; a < 64; a++) begin
      addr = 6'(a);
      #1;
      chk($sformatf("post_clr_rd_%0d", a), b0.dout, 16'h0000);
    end

    // reset in the middle of a clr-started sequence
    we = 1'b1; di = 16'hFFFF; be = 2'b11;
    for (int a = 0; a < 64; a++) begin
      addr = 6'(a);
      tick();
    end
    en = 1'b0; we = 1'b0; clr = 1'b1;
    tick();
    clr = 1'b0;
    repeat (20) tick();
    rst = 1'b1;
    #1;
    chk("midrst_ready_m1", 16'(b1.ready), 16'h0);
    chk("midrst_dout_m2", b2.dout, 16'h0000);
    chk("midrst_ready_noclr", 16'(b3.ready), 16'h1);
    en = 1'b1; addr = 6'd19;
    #1;
    chk("abort_word19", b3.dout, 16'h0000);
    addr = 6'd20;
    #1;
    chk("abort_word20", b3.dout, 16'hFFFF);
    en = 1'b0;
    tick();
    rst = 1'b0;
    #1;
    low = 0;
    while (b1.ready !== 1'b1 && low < 200) begin
      low++;
      tick();
    end
    chk("restart_len", 16'(low), 16'd64);
    en = 1'b1; addr = 6'd20;
    #1;
    chk("restart_word20", b0.dout, 16'h0000);
    addr = 6'd63;
    #1;
    chk("restart_word63", b0.dout, 16'h0000);
    en = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/dmem_ctrl.md
Name: dmem_ctrl

Overview:
Parametrised synchronous-write data memory for the single-cycle/multicycle datapaths; successor to the fixed 16x64 data memory. Adds byte-lane write strobes, selectable read mode (async, sync read-first, sync write-first) and a hardware clear sequencer that zeroes every word after reset or on request. Sits between the datapath load/store unit and nothing else; the datapath stalls on ready=0.

Parameters:
ADDR_WIDTH, 6, word-address width; depth = 2**ADDR_WIDTH words
DATA_WIDTH, 16, word width in bits
LANE_WIDTH, 8, write-strobe granularity; DATA_WIDTH must be an integer multiple (LANE_WIDTH=DATA_WIDTH gives one strobe bit)
READ_MODE, 0, 0 = async read, 1 = sync read-first, 2 = sync write-first
CLEAR_ON_RESET, 1, 1 = run clear sequence on reset exit; 0 = ready immediately after reset

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  asynchronous, active-high reset
en  in  1  access enable; no read update or write when 0
we  in  1  write enable, qualified by en
be  in  DATA_WIDTH/LANE_WIDTH  byte-lane strobes; lane i = di[i*LANE_WIDTH +: LANE_WIDTH]
addr  in  ADDR_WIDTH  word address
di  in  DATA_WIDTH  write data
clr  in  1  request memory clear; sampled only in IDLE
dout  out  DATA_WIDTH  read data
rvalid  out  1  dout holds data for an accepted read
ready  out  1  1 = accesses accepted; 0 = clear in progress

Behaviour:
- Reset (rst=1, async): state = CLEAR if CLEAR_ON_RESET else IDLE; clear pointer = 0; dout = 0; rvalid = 0; ready = 0 if CLEAR_ON_RESET else 1. Array contents not touched by rst itself.
- States: IDLE, CLEAR. IDLE->CLEAR when clr=1 on an edge (same-edge en/we ignored). CLEAR writes 0 to word[ptr], ptr++ each cycle; on write of last word (ptr = 2**ADDR_WIDTH-1) -> IDLE, ptr = 0. Clear lasts exactly 2**ADDR_WIDTH cycles; ready=1 the cycle after the last clear write.
- ready = (state==IDLE), registered. In CLEAR: en/we/be/clr ignored, dout holds, rvalid=0.
- rst during CLEAR restarts the sequence at ptr 0 (CLEAR_ON_RESET=1) or aborts to IDLE (=0); partially cleared words stay.
- Write (IDLE, en=1, we=1): for each lane i with be[i]=1, word[addr] lane i <= di lane i; lanes with be[i]=0 unchanged. we=1 with be=0 is a no-op write (still a read for sync modes).
- READ_MODE 0: dout = word[addr] combinationally whenever ready (0 in CLEAR); rvalid = en & ready, combinational. A write is visible on dout the cycle after the edge.
- READ_MODE 1: on edge with en=1 & ready: dout <= word[addr] pre-write value; rvalid <= 1. Latency 1.
- READ_MODE 2: as mode 1 but dout <= merged post-write word (strobed lanes from di, others old).
- Sync modes, en=0 or not ready: dout holds last value, rvalid <= 0.
- Address wraps naturally (no out-of-range); no read/write hazards beyond the mode rules above.
- Illegal parameters (DATA_WIDTH % LANE_WIDTH != 0, READ_MODE>2) are elaboration errors.

Test Plan:
Reset release, defaults, CLEAR_ON_RESET=1 -> ready=0 for 64 cycles, ready=1 on cycle 65; read all 64 addrs -> 0x0000.
Mode 1: write addr 5 di=0xABCD be=11, then same-edge write addr 5 di=0x1234 be=11 with en=1 -> dout=0xABCD one cycle later, next read dout=0x1234.
Mode 2, word 5=0xABCD: write di=0x1234 be=01 -> dout=0xAB34 same following cycle; be=00 write -> word unchanged 0xAB34.
Mode 0: write addr 9 = 0x00FF, set addr=9 en=1 next cycle -> dout=0x00FF and rvalid=1 combinationally; en=0 -> rvalid=0.
Fill memory with 0xFFFF, pulse clr -> ready low 64 cycles, writes during clear ignored, afterwards all words 0x0000.
Assert rst at clear cycle 20 of a clr-started sequence -> ready stays 0, clear restarts, completes 64 cycles after rst release.
